// File: rtl/axi_mem_window_guard.sv
// AXI4 window guard: forwards bursts fully inside [BASE, BASE+SIZE), answers everything else with DECERR.
// Optional GUARD_STATS_EN adds a saturating reject counter and a sticky first-reject address.
module axi_mem_window_guard #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4,
  parameter logic [ADDR_W-1:0] BASE = 32'h8000_0000,
  parameter logic [ADDR_W-1:0] SIZE = 32'h1000_0000,
  parameter int OUTS_W = 4
) (
  input  logic                uncoreclk,
  input  logic                uncorerst,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awlock,
  input  logic [3:0]          s_axi_awcache,
  input  logic [2:0]          s_axi_awprot,
  input  logic [3:0]          s_axi_awqos,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arlock,
  input  logic [3:0]          s_axi_arcache,
  input  logic [2:0]          s_axi_arprot,
  input  logic [3:0]          s_axi_arqos,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic [ID_W-1:0]     m_axi_awid,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic [3:0]          m_axi_awqos,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [ID_W-1:0]     m_axi_bid,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic [ID_W-1:0]     m_axi_arid,
  output logic [ADDR_W-1:0]   m_axi_araddr,
  output logic [7:0]          m_axi_arlen,
  output logic [2:0]          m_axi_arsize,
  output logic [1:0]          m_axi_arburst,
  output logic                m_axi_arlock,
  output logic [3:0]          m_axi_arcache,
  output logic [2:0]          m_axi_arprot,
  output logic [3:0]          m_axi_arqos,
  output logic                m_axi_arvalid,
  input  logic                m_axi_arready,
  input  logic [ID_W-1:0]     m_axi_rid,
  input  logic [DATA_W-1:0]   m_axi_rdata,
  input  logic [1:0]          m_axi_rresp,
  input  logic                m_axi_rlast,
  input  logic                m_axi_rvalid,
  output logic                m_axi_rready,
  output logic [15:0]         err_cnt,
  output logic [ADDR_W-1:0]   err_addr
);

  localparam logic [ADDR_W:0] ONE      = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] WIN_BASE = {1'b0, BASE};
  localparam logic [ADDR_W:0] WIN_LAST = {1'b0, BASE} + {1'b0, SIZE} - ONE;

  typedef enum logic [2:0] {W_IDLE, W_PASS, W_DRAIN, W_WAIT, W_RESP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_e;

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic [OUTS_W-1:0] wr_outs_q, rd_outs_q;
  logic [ID_W-1:0]   awid_q, awid_d, arid_q, arid_d;
  logic [7:0]        arlen_q, arlen_d, beat_q, beat_d;
  logic              aw_in, ar_in, wr_full, rd_full;
  logic              aw_fire, b_fire, ar_fire, r_done;

  // One extra bit of arithmetic catches bursts that wrap past the top of the address space.
  function automatic logic in_window(input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                                     input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_W:0] bytes, start, last;
    bytes = ((ADDR_W+1)'(len) + ONE) << size;
    if (burst == 2'b00) bytes = ONE << size;
    start = {1'b0, addr};
    if (burst == 2'b10) start = start & ~(bytes - ONE);
    last = start + bytes - ONE;
    return (burst != 2'b11) && (start >= WIN_BASE) && (last <= WIN_LAST) && !last[ADDR_W];
  endfunction

  assign aw_in   = in_window(s_axi_awaddr, s_axi_awlen, s_axi_awsize, s_axi_awburst);
  assign ar_in   = in_window(s_axi_araddr, s_axi_arlen, s_axi_arsize, s_axi_arburst);
  assign wr_full = (wr_outs_q == {OUTS_W{1'b1}});
  assign rd_full = (rd_outs_q == {OUTS_W{1'b1}});

  assign m_axi_awid = s_axi_awid;       assign m_axi_awaddr  = s_axi_awaddr;
  assign m_axi_awlen = s_axi_awlen;     assign m_axi_awsize  = s_axi_awsize;
  assign m_axi_awburst = s_axi_awburst; assign m_axi_awlock  = s_axi_awlock;
  assign m_axi_awcache = s_axi_awcache; assign m_axi_awprot  = s_axi_awprot;
  assign m_axi_awqos = s_axi_awqos;     assign m_axi_wdata   = s_axi_wdata;
  assign m_axi_wstrb = s_axi_wstrb;     assign m_axi_wlast   = s_axi_wlast;
  assign m_axi_arid = s_axi_arid;       assign m_axi_araddr  = s_axi_araddr;
  assign m_axi_arlen = s_axi_arlen;     assign m_axi_arsize  = s_axi_arsize;
  assign m_axi_arburst = s_axi_arburst; assign m_axi_arlock  = s_axi_arlock;
  assign m_axi_arcache = s_axi_arcache; assign m_axi_arprot  = s_axi_arprot;
  assign m_axi_arqos = s_axi_arqos;

  assign aw_fire = m_axi_awvalid && m_axi_awready;
  assign b_fire  = m_axi_bvalid && m_axi_bready;
  assign ar_fire = m_axi_arvalid && m_axi_arready;
  assign r_done  = m_axi_rvalid && m_axi_rready && m_axi_rlast;

  always_comb begin
    w_state_d = w_state_q;  r_state_d = r_state_q;
    awid_d = awid_q;  arid_d = arid_q;  arlen_d = arlen_q;  beat_d = beat_q;
    s_axi_awready = 1'b0;  m_axi_awvalid = 1'b0;
    s_axi_wready  = 1'b0;  m_axi_wvalid  = 1'b0;
    s_axi_bvalid  = 1'b0;  s_axi_bid = m_axi_bid;  s_axi_bresp = m_axi_bresp;  m_axi_bready = 1'b0;
    s_axi_arready = 1'b0;  m_axi_arvalid = 1'b0;
    s_axi_rvalid  = 1'b0;  s_axi_rid = m_axi_rid;  s_axi_rdata = m_axi_rdata;
    s_axi_rresp   = m_axi_rresp;  s_axi_rlast = m_axi_rlast;  m_axi_rready = 1'b0;
    // Handshake outputs are held low for as long as reset is asserted.
    if (!uncorerst) begin
      case (w_state_q)
        W_IDLE: if (s_axi_awvalid && !wr_full) begin
          if (aw_in) begin
            m_axi_awvalid = 1'b1;
            s_axi_awready = m_axi_awready;
            if (m_axi_awready) w_state_d = W_PASS;
          end else begin
            s_axi_awready = 1'b1;
            awid_d        = s_axi_awid;
            w_state_d     = W_DRAIN;
          end
        end
        W_PASS: begin
          m_axi_wvalid = s_axi_wvalid;
          s_axi_wready = m_axi_wready;
          if (s_axi_wvalid && m_axi_wready && s_axi_wlast) w_state_d = W_IDLE;
        end
        W_DRAIN: begin
          s_axi_wready = 1'b1;
          if (s_axi_wvalid && s_axi_wlast) w_state_d = W_WAIT;
        end
        W_WAIT: if (wr_outs_q == '0) w_state_d = W_RESP;
        W_RESP: begin
          s_axi_bvalid = 1'b1;
          s_axi_bresp  = 2'b11;
          s_axi_bid    = awid_q;
          if (s_axi_bready) w_state_d = W_IDLE;
        end
        default: w_state_d = W_IDLE;
      endcase
      if (w_state_q != W_RESP) begin
        s_axi_bvalid = m_axi_bvalid;
        m_axi_bready = s_axi_bready;
      end

      case (r_state_q)
        R_IDLE: if (s_axi_arvalid) begin
          if (ar_in) begin
            if (!rd_full) begin
              m_axi_arvalid = 1'b1;
              s_axi_arready = m_axi_arready;
            end
          end else begin
            s_axi_arready = 1'b1;
            arid_d        = s_axi_arid;
            arlen_d       = s_axi_arlen;
            r_state_d     = R_WAIT;
          end
        end
        R_WAIT: if (rd_outs_q == '0) begin
          beat_d    = 8'd0;
          r_state_d = R_RESP;
        end
        R_RESP: begin
          s_axi_rvalid = 1'b1;
          s_axi_rid    = arid_q;
          s_axi_rdata  = '0;
          s_axi_rresp  = 2'b11;
          s_axi_rlast  = (beat_q == arlen_q);
          if (s_axi_rready) begin
            beat_d = beat_q + 8'd1;
            if (beat_q == arlen_q) r_state_d = R_IDLE;
          end
        end
        default: r_state_d = R_IDLE;
      endcase
      if (r_state_q != R_RESP) begin
        s_axi_rvalid = m_axi_rvalid;
        m_axi_rready = s_axi_rready;
      end
    end
  end

  always_ff @(posedge uncoreclk) begin
    if (uncorerst) begin
      w_state_q <= W_IDLE;  r_state_q <= R_IDLE;
      wr_outs_q <= '0;      rd_outs_q <= '0;
      awid_q <= '0;  arid_q <= '0;  arlen_q <= '0;  beat_q <= '0;
    end else begin
      w_state_q <= w_state_d;  r_state_q <= r_state_d;
      awid_q <= awid_d;  arid_q <= arid_d;  arlen_q <= arlen_d;  beat_q <= beat_d;
      case ({aw_fire, b_fire})
        2'b10:   wr_outs_q <= wr_outs_q + 1'b1;
        2'b01:   wr_outs_q <= wr_outs_q - 1'b1;
        default: wr_outs_q <= wr_outs_q;
      endcase
      case ({ar_fire, r_done})
        2'b10:   rd_outs_q <= rd_outs_q + 1'b1;
        2'b01:   rd_outs_q <= rd_outs_q - 1'b1;
        default: rd_outs_q <= rd_outs_q;
      endcase
    end
  end

`ifdef GUARD_STATS_EN
  logic              aw_rej, ar_rej, err_seen_q;
  logic [1:0]        rej_n;
  logic [15:0]       err_cnt_q;
  logic [ADDR_W-1:0] err_addr_q;

  assign aw_rej = !uncorerst && (w_state_q == W_IDLE) && s_axi_awvalid && !wr_full && !aw_in;
  assign ar_rej = !uncorerst && (r_state_q == R_IDLE) && s_axi_arvalid && !ar_in;
  assign rej_n  = {1'b0, aw_rej} + {1'b0, ar_rej};

  always_ff @(posedge uncoreclk) begin
    if (uncorerst) begin
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      err_seen_q <= 1'b0;
    end else begin
      if (err_cnt_q > (16'hFFFF - {14'd0, rej_n})) err_cnt_q <= 16'hFFFF;
      else                                          err_cnt_q <= err_cnt_q + {14'd0, rej_n};
      if (!err_seen_q && (aw_rej || ar_rej)) begin
        err_seen_q <= 1'b1;
        err_addr_q <= aw_rej ? s_axi_awaddr : s_axi_araddr;
      end
    end
  end

  assign err_cnt  = err_cnt_q;
  assign err_addr = err_addr_q;
`else
  assign err_cnt  = '0;
  assign err_addr = '0;
`endif

endmodule

// File: tb/tb_axi_mem_window_guard.sv
// Directed scoreboard bench for axi_mem_window_guard: the bench plays both core and downstream slave.
module tb_axi_mem_window_guard;

  logic        uncoreclk = 1'b0;
  logic        uncorerst;
  logic [3:0]  s_awid, s_arid, m_awid, m_arid, s_bid, m_bid, s_rid, m_rid;
  logic [31:0] s_awaddr, s_araddr, m_awaddr, m_araddr, err_addr;
  logic [7:0]  s_awlen, s_arlen, m_awlen, m_arlen;
  logic [2:0]  s_awsize, s_arsize, m_awsize, m_arsize, s_awprot, s_arprot, m_awprot, m_arprot;
  logic [1:0]  s_awburst, s_arburst, m_awburst, m_arburst, s_bresp, m_bresp, s_rresp, m_rresp;
  logic        s_awlock, s_arlock, m_awlock, m_arlock;
  logic [3:0]  s_awcache, s_arcache, m_awcache, m_arcache, s_awqos, s_arqos, m_awqos, m_arqos;
  logic        s_awvalid, s_awready, m_awvalid, m_awready, s_arvalid, s_arready, m_arvalid, m_arready;
  logic [63:0] s_wdata, m_wdata, s_rdata, m_rdata;
  logic [7:0]  s_wstrb, m_wstrb;
  logic        s_wlast, m_wlast, s_wvalid, s_wready, m_wvalid, m_wready;
  logic        s_bvalid, s_bready, m_bvalid, m_bready;
  logic        s_rlast, m_rlast, s_rvalid, s_rready, m_rvalid, m_rready;
  logic [15:0] err_cnt;

  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_t;
  typedef struct packed { logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last; } r_t;
  b_t exp_b_q[$];
  r_t exp_r_q[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 uncoreclk = ~uncoreclk;

  axi_mem_window_guard dut (
    .uncoreclk(uncoreclk), .uncorerst(uncorerst),
    .s_axi_awid(s_awid), .s_axi_awaddr(s_awaddr), .s_axi_awlen(s_awlen), .s_axi_awsize(s_awsize),
    .s_axi_awburst(s_awburst), .s_axi_awlock(s_awlock), .s_axi_awcache(s_awcache),
    .s_axi_awprot(s_awprot), .s_axi_awqos(s_awqos), .s_axi_awvalid(s_awvalid), .s_axi_awready(s_awready),
    .s_axi_wdata(s_wdata), .s_axi_wstrb(s_wstrb), .s_axi_wlast(s_wlast), .s_axi_wvalid(s_wvalid),
    .s_axi_wready(s_wready), .s_axi_bid(s_bid), .s_axi_bresp(s_bresp), .s_axi_bvalid(s_bvalid),
    .s_axi_bready(s_bready),
    .s_axi_arid(s_arid), .s_axi_araddr(s_araddr), .s_axi_arlen(s_arlen), .s_axi_arsize(s_arsize),
    .s_axi_arburst(s_arburst), .s_axi_arlock(s_arlock), .s_axi_arcache(s_arcache),
    .s_axi_arprot(s_arprot), .s_axi_arqos(s_arqos), .s_axi_arvalid(s_arvalid), .s_axi_arready(s_arready),
    .s_axi_rid(s_rid), .s_axi_rdata(s_rdata), .s_axi_rresp(s_rresp), .s_axi_rlast(s_rlast),
    .s_axi_rvalid(s_rvalid), .s_axi_rready(s_rready),
    .m_axi_awid(m_awid), .m_axi_awaddr(m_awaddr), .m_axi_awlen(m_awlen), .m_axi_awsize(m_awsize),
    .m_axi_awburst(m_awburst), .m_axi_awlock(m_awlock), .m_axi_awcache(m_awcache),
    .m_axi_awprot(m_awprot), .m_axi_awqos(m_awqos), .m_axi_awvalid(m_awvalid), .m_axi_awready(m_awready),
    .m_axi_wdata(m_wdata), .m_axi_wstrb(m_wstrb), .m_axi_wlast(m_wlast), .m_axi_wvalid(m_wvalid),
    .m_axi_wready(m_wready), .m_axi_bid(m_bid), .m_axi_bresp(m_bresp), .m_axi_bvalid(m_bvalid),
    .m_axi_bready(m_bready),
    .m_axi_arid(m_arid), .m_axi_araddr(m_araddr), .m_axi_arlen(m_arlen), .m_axi_arsize(m_arsize),
    .m_axi_arburst(m_arburst), .m_axi_arlock(m_arlock), .m_axi_arcache(m_arcache),
    .m_axi_arprot(m_arprot), .m_axi_arqos(m_arqos), .m_axi_arvalid(m_arvalid), .m_axi_arready(m_arready),
    .m_axi_rid(m_rid), .m_axi_rdata(m_rdata), .m_axi_rresp(m_rresp), .m_axi_rlast(m_rlast),
    .m_axi_rvalid(m_rvalid), .m_axi_rready(m_rready),
    .err_cnt(err_cnt), .err_addr(err_addr)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge uncoreclk);
    #1;
  endtask

  task automatic do_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] burst, input logic fwd);
    int n = 0;
    s_awvalid = 1'b1; s_awid = id; s_awaddr = addr; s_awlen = len; s_awsize = size; s_awburst = burst;
    m_awready = 1'b1;
    #1;
    while (!s_awready && n < 30) begin tick(); #1; n++; end
    check("aw_accept", s_awready, 1);
    check("aw_fwd", m_awvalid, fwd);
    if (fwd) begin
      check("aw_addr", m_awaddr, addr);
      check("aw_len", m_awlen, len);
    end
    $display("AW id=%0h addr=%08h len=%0d fwd=%0d", id, addr, len, fwd);
    tick();
    s_awvalid = 1'b0;
  endtask

  task automatic do_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                       input logic fwd);
    int n = 0;
    s_arvalid = 1'b1; s_arid = id; s_araddr = addr; s_arlen = len; s_arsize = 3'd3; s_arburst = 2'b01;
    m_arready = 1'b1;
    #1;
    while (!s_arready && n < 30) begin tick(); #1; n++; end
    check("ar_accept", s_arready, 1);
    check("ar_fwd", m_arvalid, fwd);
    $display("AR id=%0h addr=%08h len=%0d fwd=%0d", id, addr, len, fwd);
    tick();
    s_arvalid = 1'b0;
  endtask

  task automatic probe_ar(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic exp_in);
    s_arvalid = 1'b1; s_araddr = addr; s_arlen = len; s_arsize = size; s_arburst = burst;
    m_arready = 1'b0;
    #1;
    check("probe_fwd", m_arvalid, exp_in);
    check("probe_rej", s_arready, !exp_in);
    $display("PROBE addr=%08h len=%0d size=%0d burst=%0d in=%0d", addr, len, size, burst, exp_in);
    s_arvalid = 1'b0;
    tick();
  endtask

  task automatic do_w(input int beats, input logic fwd, input logic [63:0] base);
    for (int b = 0; b < beats; b++) begin
      s_wvalid = 1'b1; s_wdata = base + 64'(b); s_wstrb = 8'hFF; s_wlast = (b == beats - 1);
      m_wready = 1'b1;
      #1;
      check("w_ready", s_wready, 1);
      check("w_fwd", m_wvalid, fwd);
      if (fwd) check("w_data", m_wdata, base + 64'(b));
      $display("W beat=%0d data=%0h fwd=%0d", b, base + 64'(b), fwd);
      tick();
    end
    s_wvalid = 1'b0; s_wlast = 1'b0;
  endtask

  task automatic expect_b();
    int n = 0;
    b_t e;
    s_bready = 1'b1;
    #1;
    while (!s_bvalid && n < 40) begin tick(); #1; n++; end
    check("b_valid", s_bvalid, 1);
    if (exp_b_q.size() == 0) check("b_unexpected", s_bvalid, 0);
    else begin
      e = exp_b_q.pop_front();
      check("b_id", s_bid, e.id);
      check("b_resp", s_bresp, e.resp);
      $display("B id=%0h resp=%0d", s_bid, s_bresp);
    end
    tick();
    s_bready = 1'b0;
  endtask

  task automatic expect_r();
    int n = 0;
    r_t e;
    s_rready = 1'b1;
    #1;
    while (!s_rvalid && n < 40) begin tick(); #1; n++; end
    check("r_valid", s_rvalid, 1);
    if (exp_r_q.size() == 0) check("r_unexpected", s_rvalid, 0);
    else begin
      e = exp_r_q.pop_front();
      check("r_id", s_rid, e.id);
      check("r_data", s_rdata, e.data);
      check("r_resp", s_rresp, e.resp);
      check("r_last", s_rlast, e.last);
      $display("R id=%0h data=%0h resp=%0d last=%0d", s_rid, s_rdata, s_rresp, s_rlast);
    end
    tick();
    s_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    uncorerst = 1'b1;
    s_awid = '0; s_awaddr = '0; s_awlen = '0; s_awsize = 3'd3; s_awburst = 2'b01; s_awlock = 1'b0;
    s_awcache = 4'h3; s_awprot = 3'd0; s_awqos = 4'd0; s_awvalid = 1'b0;
    s_arid = '0; s_araddr = '0; s_arlen = '0; s_arsize = 3'd3; s_arburst = 2'b01; s_arlock = 1'b0;
    s_arcache = 4'h3; s_arprot = 3'd0; s_arqos = 4'd0; s_arvalid = 1'b0;
    s_wdata = '0; s_wstrb = '0; s_wlast = 1'b0; s_wvalid = 1'b0; s_bready = 1'b0; s_rready = 1'b0;
    m_awready = 1'b0; m_wready = 1'b0; m_bid = '0; m_bresp = '0; m_bvalid = 1'b0; m_arready = 1'b0;
    m_rid = '0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rvalid = 1'b0;

    // Reset state, including requests presented while reset is held.
    repeat (3) tick();
    s_awvalid = 1'b1; s_awaddr = 32'h0000_1000; s_arvalid = 1'b1; s_araddr = 32'h0000_1000;
    #1;
    check("rst_awready", s_awready, 0);
    check("rst_arready", s_arready, 0);
    check("rst_awvalid", m_awvalid, 0);
    check("rst_wready", s_wready, 0);
    check("rst_bvalid", s_bvalid, 0);
    check("rst_rvalid", s_rvalid, 0);
    s_awvalid = 1'b0; s_arvalid = 1'b0;
    uncorerst = 1'b0;
    tick();

    // Legal INCR write: forwarded, 4 beats pass, OKAY from downstream.
    do_aw(4'h5, 32'h8000_0000, 8'd3, 3'd3, 2'b01, 1'b1);
    do_w(4, 1'b1, 64'hA000);
    m_bvalid = 1'b1; m_bid = 4'h5; m_bresp = 2'b00;
    exp_b_q.push_back('{id: 4'h5, resp: 2'b00});
    expect_b();
    m_bvalid = 1'b0;

    // Read crossing the window top: answered locally.
    exp_r_q.push_back('{id: 4'h3, data: 64'd0, resp: 2'b11, last: 1'b0});
    exp_r_q.push_back('{id: 4'h3, data: 64'd0, resp: 2'b11, last: 1'b1});
    do_ar(4'h3, 32'h8FFF_FFF8, 8'd1, 1'b0);
    expect_r();
    expect_r();

    // Decode boundaries.
    probe_ar(32'h8FFF_FFF8, 8'd3, 3'd3, 2'b00, 1'b1);
    probe_ar(32'h8FFF_FFF8, 8'd3, 3'd3, 2'b10, 1'b1);
    probe_ar(32'h8000_0000, 8'd0, 3'd3, 2'b11, 1'b0);
    probe_ar(32'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 1'b0);
    probe_ar(32'hFFFF_FFF8, 8'd1, 3'd3, 2'b01, 1'b0);
    probe_ar(32'h8FFF_FFF0, 8'd1, 3'd3, 2'b01, 1'b1);

    // Out-of-window write: beats absorbed, single DECERR with original id.
    do_aw(4'h9, 32'h0000_1000, 8'd7, 3'd3, 2'b01, 1'b0);
    do_w(8, 1'b0, 64'hB000);
    exp_b_q.push_back('{id: 4'h9, resp: 2'b11});
    expect_b();

    // Three legal reads outstanding, then a bad read that must wait behind them.
    exp_r_q.push_back('{id: 4'h1, data: 64'hD1, resp: 2'b00, last: 1'b1});
    do_ar(4'h1, 32'h8000_0100, 8'd0, 1'b1);
    exp_r_q.push_back('{id: 4'h2, data: 64'hD2, resp: 2'b00, last: 1'b1});
    do_ar(4'h2, 32'h8000_0200, 8'd0, 1'b1);
    exp_r_q.push_back('{id: 4'h1, data: 64'hD3, resp: 2'b00, last: 1'b1});
    do_ar(4'h1, 32'h8000_0300, 8'd0, 1'b1);
    exp_r_q.push_back('{id: 4'h7, data: 64'd0, resp: 2'b11, last: 1'b1});
    do_ar(4'h7, 32'h4000_0000, 8'd0, 1'b0);
    repeat (3) tick();
    #1;
    check("decerr_held", s_rvalid, 0);
    for (int i = 0; i < 3; i++) begin
      m_rvalid = 1'b1; m_rlast = 1'b1; m_rresp = 2'b00;
      m_rid = (i == 1) ? 4'h2 : 4'h1;
      m_rdata = 64'hD1 + 64'(i);
      expect_r();
      m_rvalid = 1'b0;
    end
    expect_r();

`ifdef GUARD_STATS_EN
    check("stats_cnt", err_cnt, 16'd3);
    check("stats_addr", err_addr, 32'h8FFF_FFF8);
`else
    check("stats_cnt", err_cnt, 16'd0);
    check("stats_addr", err_addr, 32'd0);
`endif

    // Fill the write outstanding counter to 15 with B held off.
    for (int i = 0; i < 15; i++) begin
      do_aw(4'(i), 32'h8000_0000 + 32'(i * 64), 8'd0, 3'd3, 2'b01, 1'b1);
      do_w(1, 1'b1, 64'(i));
    end
    s_awvalid = 1'b1; s_awid = 4'hF; s_awaddr = 32'h8000_1000; s_awlen = 8'd0;
    #1;
    check("aw_stall", s_awready, 0);
    check("aw_stall_fwd", m_awvalid, 0);
    tick();
    check("aw_stall2", s_awready, 0);
    m_bvalid = 1'b1; m_bid = 4'h0; m_bresp = 2'b00;
    exp_b_q.push_back('{id: 4'h0, resp: 2'b00});
    expect_b();
    m_bvalid = 1'b0;
    #1;
    check("aw_resume", s_awready, 1);
    tick();
    s_awvalid = 1'b0;
    do_w(1, 1'b1, 64'hF0);

    // Reset in the middle of a drain, then a clean write.
    uncorerst = 1'b1;
    tick();
    uncorerst = 1'b0;
    tick();
    do_aw(4'h6, 32'h0000_2000, 8'd3, 3'd3, 2'b01, 1'b0);
    do_w(2, 1'b0, 64'hC000);
    uncorerst = 1'b1;
    s_wvalid = 1'b1; s_wlast = 1'b1;
    tick();
    check("rstd_wready", s_wready, 0);
    check("rstd_bvalid", s_bvalid, 0);
    check("rstd_mwvalid", m_wvalid, 0);
    check("rstd_awready", s_awready, 0);
    uncorerst = 1'b0;
    tick();
    check("idle_wready", s_wready, 0);
    check("idle_bvalid", s_bvalid, 0);
    check("idle_mwvalid", m_wvalid, 0);
    s_wvalid = 1'b0; s_wlast = 1'b0;
    do_aw(4'h4, 32'h8123_4000, 8'd1, 3'd3, 2'b01, 1'b1);
    do_w(2, 1'b1, 64'hE000);
    tick();
    check("no_stale_b", s_bvalid, 0);
    m_bvalid = 1'b1; m_bid = 4'h4; m_bresp = 2'b00;
    exp_b_q.push_back('{id: 4'h4, resp: 2'b00});
    expect_b();
    m_bvalid = 1'b0;

    check("sb_b_empty", 64'(exp_b_q.size()), 0);
    check("sb_r_empty", 64'(exp_r_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
